// File: rtl/conv_pkg.sv
// Shared definitions for the conv accelerator and its host DMA: FSM states,
// memory size defaults and the byte-lane packing helper.
package conv_pkg;

    // Host DMA job sequencing states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        KICK  = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam int unsigned DSIZE_DEFAULT = 1024;
    localparam int unsigned AW_DEFAULT    = $clog2(DSIZE_DEFAULT) + 1;
    localparam int unsigned LANES         = 4;

    // Place byte b into lane 'lane' of a 32-bit little-endian word
    function automatic logic [31:0] pack_lane(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[8*lane +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/conv_word_packer.sv
// Packs a byte stream into 32-bit words. A word is written when lane 3 fills
// or the job's last byte arrives; unused lanes of a partial word read as zero.
module conv_word_packer
    import conv_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic [7:0]    in_data,
    output logic          wr,
    output logic [AW-1:0] addr,
    output logic [31:0]   data
);

    logic [1:0]    lane;
    logic [31:0]   acc;
    logic [AW-1:0] base;
    logic [31:0]   acc_n;
    logic          flush;

    // Accumulator with the incoming byte merged into its lane
    always_comb begin
        acc_n = pack_lane(acc, lane, in_data);
        flush = in_valid && ((lane == 2'd3) || in_last);
    end

    // Lane accumulation and registered word emission
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= 2'd0;
            acc  <= 32'd0;
            base <= '0;
            wr   <= 1'b0;
            addr <= '0;
            data <= 32'd0;
        end else begin
            wr <= 1'b0;
            if (clr) begin
                lane <= 2'd0;
                acc  <= 32'd0;
                base <= '0;
            end else if (in_valid) begin
                if (flush) begin
                    data <= acc_n;
                    addr <= base;
                    wr   <= 1'b1;
                    acc  <= 32'd0;
                    lane <= 2'd0;
                    base <= base + AW'(LANES);
                end else begin
                    acc  <= acc_n;
                    lane <= lane + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_host_dma.sv
// Host-side initiator for one conv instance: loads the input image through the
// input-memory port, kicks the conv, waits for done, then streams the result
// window back out as bytes with a last flag.
// Optional feature macro: CONV_HOST_PERF_EN (adds perf_cycles, WAIT cycle count).
module conv_host_dma
    import conv_pkg::*;
#(
    parameter int unsigned DSIZE = DSIZE_DEFAULT,
    parameter int unsigned AW    = $clog2(DSIZE) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [7:0]    data_width,
    input  logic [7:0]    data_height,
    input  logic [7:0]    result_width,
    input  logic [7:0]    result_height,
    output logic          busy,
    output logic          job_done,
    output logic          err,
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [7:0]    m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic [AW-1:0] mi_addr,
    output logic [31:0]   mi_data,
    output logic          mi_wr,
    output logic [AW-1:0] mo_addr,
    input  logic [31:0]   mo_data,
    output logic          conv_start,
    input  logic          conv_done
`ifdef CONV_HOST_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    state_t      state, state_n;
    logic [15:0] n_req;
    logic        req_bad;
    logic        accept_go, reject_go;
    logic [7:0]  w_q, rw_q, rh_q;
    logic [15:0] n_q;
    logic [15:0] byte_cnt;
    logic        s_fire, last_byte;
    logic [7:0]  x, y;
    logic [15:0] row_base;
    logic        fetch_done;
    logic        fetch, last_fetch, m_accept;
    logic        mo_data_unused;

    assign mo_data_unused = ^mo_data[31:8];

    // Job size check and handshake decodes
    always_comb begin
        n_req      = 16'(data_width) * 16'(data_height);
        req_bad    = (n_req == 16'd0) || (n_req > 16'(DSIZE));
        s_fire     = s_valid && s_ready;
        last_byte  = (byte_cnt == (n_q - 16'd1));
        m_accept   = m_valid && m_ready;
        fetch      = (state == DRAIN) && !fetch_done && (!m_valid || m_ready);
        last_fetch = (x == rw_q) && (y == rh_q);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n   = state;
        accept_go = 1'b0;
        reject_go = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    if (req_bad) begin
                        reject_go = 1'b1;
                    end else begin
                        accept_go = 1'b1;
                        state_n   = LOAD;
                    end
                end
            end
            LOAD:    if (s_fire && last_byte) state_n = KICK;
            KICK:    state_n = WAIT;
            WAIT:    if (conv_done) state_n = DRAIN;
            DRAIN:   if (m_accept && m_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    conv_word_packer #(.AW(AW)) u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept_go),
        .in_valid (s_fire),
        .in_last  (last_byte),
        .in_data  (s_data),
        .wr       (mi_wr),
        .addr     (mi_addr),
        .data     (mi_data)
    );

    // Job config latches, status flags and control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q        <= 8'd0;
            rw_q       <= 8'd0;
            rh_q       <= 8'd0;
            n_q        <= 16'd0;
            byte_cnt   <= 16'd0;
            err        <= 1'b0;
            job_done   <= 1'b0;
            busy       <= 1'b0;
            s_ready    <= 1'b0;
            conv_start <= 1'b0;
        end else begin
            busy       <= (state_n != IDLE);
            s_ready    <= (state_n == LOAD);
            conv_start <= (state_n == KICK);
            job_done   <= reject_go || ((state == DRAIN) && m_accept && m_last);
            if (accept_go) begin
                w_q      <= data_width;
                rw_q     <= result_width;
                rh_q     <= result_height;
                n_q      <= n_req;
                byte_cnt <= 16'd0;
                err      <= 1'b0;
            end else if (reject_go) begin
                err <= 1'b1;
            end
            if (s_fire) byte_cnt <= byte_cnt + 16'd1;
        end
    end

    // Result window walk and output register slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x          <= 8'd0;
            y          <= 8'd0;
            row_base   <= 16'd0;
            fetch_done <= 1'b0;
            mo_addr    <= '0;
            m_data     <= 8'd0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
        end else begin
            if ((state == WAIT) && conv_done) begin
                x          <= 8'd0;
                y          <= 8'd0;
                row_base   <= 16'd0;
                fetch_done <= 1'b0;
                mo_addr    <= '0;
            end
            if (fetch) begin
                m_data  <= mo_data[7:0];
                m_valid <= 1'b1;
                m_last  <= last_fetch;
                if (last_fetch) fetch_done <= 1'b1;
                if (x == rw_q) begin
                    x        <= 8'd0;
                    y        <= y + 8'd1;
                    row_base <= row_base + 16'(w_q);
                    mo_addr  <= AW'(row_base + 16'(w_q));
                end else begin
                    x       <= x + 8'd1;
                    mo_addr <= AW'(row_base + 16'(x) + 16'd1);
                end
            end else if (m_accept) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

`ifdef CONV_HOST_PERF_EN
    // Cycles spent waiting on the conv for the most recent job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               perf_cycles <= 32'd0;
        else if (accept_go)       perf_cycles <= 32'd0;
        else if (state == WAIT)   perf_cycles <= perf_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_conv_host_dma.sv
// Scoreboard bench for conv_host_dma: directed jobs push expected memory writes
// and result bytes; a monitor pops and compares whenever the DUT presents them.
module tb_conv_host_dma;

    localparam int unsigned AW = 11;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } rd_t;

    logic          clk, rst_n, go;
    logic [7:0]    data_width, data_height, result_width, result_height;
    logic          busy, job_done, err;
    logic [7:0]    s_data;
    logic          s_valid, s_ready;
    logic [7:0]    m_data;
    logic          m_valid, m_ready, m_last;
    logic [AW-1:0] mi_addr, mo_addr;
    logic [31:0]   mi_data, mo_data;
    logic          mi_wr, conv_start, conv_done;
    logic          conv_done_m, stray_done, toggle;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    wr_t exp_wr[$];
    rd_t exp_rd[$];

    conv_host_dma dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .go            (go),
        .data_width    (data_width),
        .data_height   (data_height),
        .result_width  (result_width),
        .result_height (result_height),
        .busy          (busy),
        .job_done      (job_done),
        .err           (err),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .mi_addr       (mi_addr),
        .mi_data       (mi_data),
        .mi_wr         (mi_wr),
        .mo_addr       (mo_addr),
        .mo_data       (mo_data),
        .conv_start    (conv_start),
        .conv_done     (conv_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result memory model: low lane = address + 0x80, upper lanes are filler
    assign mo_data   = {24'hDEADBE, mo_addr[7:0] + 8'h80};
    assign conv_done = conv_done_m | stray_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic push_rd(input logic [7:0] d, input logic l);
        rd_t e;
        e.data = d;
        e.last = l;
        exp_rd.push_back(e);
    endtask

    task automatic start_job(input logic [7:0] w, input logic [7:0] h,
                             input logic [7:0] rw, input logic [7:0] rh);
        go = 1'b1;
        data_width = w;
        data_height = h;
        result_width = rw;
        result_height = rh;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g;
        g = 0;
        s_valid = 1'b1;
        s_data = b;
        while (!s_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready low for %0d cycles, expected high", g);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input string name);
        int g;
        g = 0;
        while (done_cnt == base && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no job_done after %0d cycles", name, g);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, 32'({busy, job_done, err, s_ready, m_valid, m_last, mi_wr, conv_start}), 32'd0);
        chk({name, "_mi_addr"}, 32'(mi_addr), 32'd0);
        chk({name, "_mi_data"}, mi_data, 32'd0);
        chk({name, "_mo_addr"}, 32'(mo_addr), 32'd0);
    endtask

    // Conv model: done pulse a few cycles after each start
    initial begin
        conv_done_m = 1'b0;
        forever begin
            @(negedge clk);
            if (conv_start) begin
                repeat (4) @(negedge clk);
                conv_done_m = 1'b1;
                @(negedge clk);
                conv_done_m = 1'b0;
            end
        end
    end

    // Downstream ready: constant high or toggling each cycle
    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (toggle) m_ready = ~m_ready;
            else        m_ready = 1'b1;
        end
    end

    // Monitor: compares writes, result bytes and stall stability
    initial begin
        wr_t ew;
        rd_t er;
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data = 8'd0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (conv_start) start_cnt++;
                if (job_done) done_cnt++;
                if (mi_wr) begin
                    if (exp_wr.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, expected none", mi_addr, mi_data);
                    end else begin
                        ew = exp_wr.pop_front();
                        chk("wr_addr", 32'(mi_addr), 32'(ew.addr));
                        chk("wr_data", mi_data, ew.data);
                    end
                end
                if (prev_stall) chk("stall_hold", {23'd0, m_valid, m_data}, {23'd0, 1'b1, prev_data});
                if (m_valid && m_ready) begin
                    if (exp_rd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: data 0x%0h last %0b, expected none", m_data, m_last);
                    end else begin
                        er = exp_rd.pop_front();
                        chk("rd_byte", {23'd0, m_last, m_data}, {23'd0, er.last, er.data});
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data = m_data;
            end
        end
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed job sequence
    initial begin
        int bs, bd;
        int g;
        rst_n = 1'b0;
        go = 1'b0;
        data_width = 8'd0;
        data_height = 8'd0;
        result_width = 8'd0;
        result_height = 8'd0;
        s_valid = 1'b0;
        s_data = 8'd0;
        toggle = 1'b0;
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 4x4 image, 2x2 result window
        push_wr(11'd0,  32'h03020100);
        push_wr(11'd4,  32'h07060504);
        push_wr(11'd8,  32'h0B0A0908);
        push_wr(11'd12, 32'h0F0E0D0C);
        push_rd(8'h80, 1'b0);
        push_rd(8'h81, 1'b0);
        push_rd(8'h84, 1'b0);
        push_rd(8'h85, 1'b1);
        bs = start_cnt;
        bd = done_cnt;
        start_job(8'd4, 8'd4, 8'd1, 8'd1);
        chk("jobA_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        wait_done(bd, "jobA");
        chk("jobA_starts", 32'(start_cnt - bs), 32'd1);
        chk("jobA_dones", 32'(done_cnt - bd), 32'd1);
        chk("jobA_err", 32'(err), 32'd0);
        chk("jobA_busy_end", 32'(busy), 32'd0);

        // 3x3 image with partial last word, drain with toggling ready
        push_wr(11'd0, 32'h03020100);
        push_wr(11'd4, 32'h07060504);
        push_wr(11'd8, 32'h00000008);
        push_rd(8'h80, 1'b0);
        push_rd(8'h81, 1'b0);
        push_rd(8'h83, 1'b0);
        push_rd(8'h84, 1'b1);
        bd = done_cnt;
        toggle = 1'b1;
        start_job(8'd3, 8'd3, 8'd1, 8'd1);
        for (int i = 0; i < 9; i++) send_byte(8'(i));
        wait_done(bd, "jobB");
        toggle = 1'b0;
        chk("jobB_dones", 32'(done_cnt - bd), 32'd1);

        // Oversized job is rejected
        bs = start_cnt;
        bd = done_cnt;
        start_job(8'd40, 8'd40, 8'd1, 8'd1);
        chk("rej_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_dones", 32'(done_cnt - bd), 32'd1);
        chk("rej_busy_later", 32'(busy), 32'd0);
        chk("rej_starts", 32'(start_cnt - bs), 32'd0);

        // 2x4 image; stray conv_done in LOAD and go during WAIT are ignored
        push_wr(11'd0, 32'h13121110);
        push_wr(11'd4, 32'h17161514);
        push_rd(8'h80, 1'b0);
        push_rd(8'h81, 1'b0);
        push_rd(8'h82, 1'b0);
        push_rd(8'h83, 1'b1);
        bs = start_cnt;
        bd = done_cnt;
        start_job(8'd2, 8'd4, 8'd1, 8'd1);
        chk("jobC_err_cleared", 32'(err), 32'd0);
        send_byte(8'h10);
        send_byte(8'h11);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        chk("jobC_stray_ready", 32'(s_ready), 32'd1);
        for (int i = 2; i < 8; i++) send_byte(8'(8'h10 + 8'(i)));
        g = 0;
        while (!conv_start && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        start_job(8'd7, 8'd2, 8'd1, 8'd1);
        wait_done(bd, "jobC");
        chk("jobC_starts", 32'(start_cnt - bs), 32'd1);
        chk("jobC_dones", 32'(done_cnt - bd), 32'd1);

        // Reset in the middle of LOAD, then a fresh 2x2 job
        push_wr(11'd0, 32'h03020100);
        start_job(8'd4, 8'd4, 8'd1, 8'd1);
        for (int i = 0; i < 6; i++) send_byte(8'(i));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_wr(11'd0, 32'hA3A2A1A0);
        push_rd(8'h80, 1'b1);
        bd = done_cnt;
        start_job(8'd2, 8'd2, 8'd0, 8'd0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + 8'(i)));
        wait_done(bd, "jobD");
        chk("jobD_dones", 32'(done_cnt - bd), 32'd1);

        chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
